fft8_in_buf: RTL and testbench
==============================

# fft8_in_buf

Input staging buffer placed directly upstream of the 8-point FFT core. It accepts a serial stream of complex samples, one per cycle under a valid/ready handshake, in natural order. It packs each group of 8 samples into a frame and presents the frame as 8 parallel complex words with a single-cycle `en` strobe, which the FFT core captures. It is double-buffered (fill bank plus output bank), so the upstream stream runs gap-free while the downstream is ready.

## Interface
- DW, 24, sample component width (signed two's complement)
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- s_valid  in  1  upstream sample valid
- s_ready  out  1  buffer can accept a sample this cycle
- s_sop  in  1  start-of-frame marker, qualified by s_valid&s_ready
- s_real, s_imag  in  DW  signed input sample
- m_ready  in  1  downstream can take a frame this cycle
- en  out  1  frame strobe to FFT; one cycle per frame
- x0_real..x7_real, x0_imag..x7_imag  out  DW each  parallel frame, x0 = first sample received
- frm_err  out  1  one-cycle pulse: partial frame discarded by s_sop resync

## Operation
- Accept = s_valid & s_ready. Fill counter cnt (0..7) gives the write index into the fill bank.
- Accepted sample with s_sop=0: written to fill[cnt]; cnt increments.
- Accepted sample with s_sop=1: written to fill[0]; cnt←1. If cnt≠0 at that time, the partial frame is dropped and frm_err pulses the next cycle. s_sop at cnt=0 is normal, with no error. Frames without any s_sop are legal; indexing follows cnt alone.
- Frame complete = accept at cnt=7 with s_sop=0. cnt wraps to 0.
- Bank states, tracked by flags `pend` (output bank holds an unissued frame) and `full` (fill bank holds a complete frame waiting):
  - EMPTY (pend=0, full=0): frame complete → copy fill to output regs, pend←1.
  - PEND (pend=1, full=0):
    - Frame complete and en this cycle → copy to output, pend stays 1.
    - Frame complete without en → full←1.
    - en without completion → pend←0.
  - PEND_FULL (pend=1, full=1): s_ready=0. On en → copy fill to output, full←0, pend stays 1.
- s_ready = !full. It is combinational from registered state only, with no dependence on s_valid or m_ready.
- en = pend & m_ready. This is combinational, and x* are output registers that stay stable while pend=1.
- Output regs change only on a copy. Between frames they hold the last issued frame.
- No arithmetic. Samples pass bit-exact, with no scaling or sign change.

## Timing
- Reset (rstn=0 at a clock edge):
  - cnt=0, pend=0, full=0; s_ready=1, en=0, frm_err=0.
  - All x* outputs are 0. The fill bank is cleared to 0.
- Reset mid-frame discards all partial and pending data. No en or frm_err is issued for the discarded data.
- Latency: 8th sample accepted at edge t → pend=1 after t → en high in cycle t+1 if m_ready=1. x* are valid in that same cycle.
- With continuous s_valid and m_ready held high: one en every 8 cycles, s_ready constantly 1, zero bubbles.
- m_ready low: the stream continues for one more full frame. s_ready drops in the cycle after the second frame completes. The first en after m_ready rises frees the fill bank, and s_ready returns to 1 in the next cycle.
- Simultaneous frame complete and en in PEND: the new frame is copied in the same edge, and en may assert again the next cycle.
- frm_err is registered: it is high for exactly one cycle after the offending s_sop edge.

## Test plan
- Reset, then 8 back-to-back samples real=k+1, imag=-(k+1), k=0..7, with m_ready=1 → en one cycle after the 8th accept; x3_real=4, x3_imag=-4; x7_real=8.
- 64 consecutive samples (ramp 0..63), continuous valid and m_ready=1 → exactly 8 en pulses spaced 8 cycles apart; the 5th frame has x0_real=32; s_ready never low.
- m_ready=0 while streaming 24 samples → s_ready goes low after sample 16 and sample 17 is stalled. Raise m_ready → en in frame order (x0_real=0, then 8, then 16), no loss.
- 3 samples, then s_sop=1 with value 100 plus 7 more samples → frm_err one pulse; the next en has x0_real=100. The first 3 samples never appear.
- rstn=0 for one cycle after 5 samples, then 8 samples starting at 200 → x* are 0 during reset; the next en frame has x0_real=200; no stale data appears.
- Max/min values (0x7FFFFF, 0x800000) are passed through unchanged at all 8 positions.

Source files
------------

// File: rtl/fft8_in_buf.sv
// fft8_in_buf: double-buffered input stager for the 8-point FFT core.
// Packs a serial valid/ready stream of complex samples into 8-word frames.
// Each frame is presented in parallel with a single-cycle en strobe.
module fft8_in_buf #(
    parameter int DW = 24
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_sop,
    input  logic signed [DW-1:0] s_real,
    input  logic signed [DW-1:0] s_imag,
    input  logic                 m_ready,
    output logic                 en,
    output logic signed [DW-1:0] x0_real,
    output logic signed [DW-1:0] x1_real,
    output logic signed [DW-1:0] x2_real,
    output logic signed [DW-1:0] x3_real,
    output logic signed [DW-1:0] x4_real,
    output logic signed [DW-1:0] x5_real,
    output logic signed [DW-1:0] x6_real,
    output logic signed [DW-1:0] x7_real,
    output logic signed [DW-1:0] x0_imag,
    output logic signed [DW-1:0] x1_imag,
    output logic signed [DW-1:0] x2_imag,
    output logic signed [DW-1:0] x3_imag,
    output logic signed [DW-1:0] x4_imag,
    output logic signed [DW-1:0] x5_imag,
    output logic signed [DW-1:0] x6_imag,
    output logic signed [DW-1:0] x7_imag,
    output logic                 frm_err
);

    // Fill bank collects the frame being received; output bank feeds the FFT.
    logic signed [DW-1:0] fillRe_q [8];
    logic signed [DW-1:0] fillIm_q [8];
    logic signed [DW-1:0] outRe_q  [8];
    logic signed [DW-1:0] outIm_q  [8];

    logic [2:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       full_q, full_d;
    logic       frmErr_q, frmErr_d;

    logic       accept;
    logic       complete;
    logic       copyNew;
    logic       copyOld;
    logic [2:0] wrIdx;

    logic signed [DW-1:0] srcRe [8];
    logic signed [DW-1:0] srcIm [8];

    // The upstream may only be stalled by a waiting complete frame in the fill bank.
    assign s_ready  = !full_q;
    assign en       = pend_q & m_ready;
    assign accept   = s_valid & s_ready;
    assign wrIdx    = s_sop ? 3'd0 : cnt_q;
    assign complete = accept & !s_sop & (cnt_q == 3'd7);

    // A freshly completed frame goes straight to the output bank when it is free
    // or is being vacated in this very cycle; otherwise it parks in the fill bank.
    assign copyNew  = complete & (!pend_q | en);
    assign copyOld  = full_q & en;

    // Copy source: the fill bank, with the 8th sample bypassed in on completion.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            srcRe[i] = fillRe_q[i];
            srcIm[i] = fillIm_q[i];
        end
        if (complete) begin
            srcRe[7] = s_real;
            srcIm[7] = s_imag;
        end
    end

    // Next-state for the fill counter, bank flags and resync error pulse.
    always_comb begin
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        full_d   = full_q;
        frmErr_d = accept & s_sop & (cnt_q != 3'd0);
        if (accept) begin
            cnt_d = s_sop ? 3'd1 : cnt_q + 3'd1;
        end
        if (copyNew || copyOld) begin
            pend_d = 1'b1;
        end else if (en) begin
            pend_d = 1'b0;
        end
        if (complete && pend_q && !en) begin
            full_d = 1'b1;
        end else if (copyOld) begin
            full_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q    <= 3'd0;
            pend_q   <= 1'b0;
            full_q   <= 1'b0;
            frmErr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            full_q   <= full_d;
            frmErr_q <= frmErr_d;
        end
    end

    // Fill bank: accepted sample lands at the counter index (slot 0 on s_sop).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) begin
                fillRe_q[i] <= '0;
                fillIm_q[i] <= '0;
            end
        end else if (accept) begin
            fillRe_q[wrIdx] <= s_real;
            fillIm_q[wrIdx] <= s_imag;
        end
    end

    // Output bank: only changes on a copy, so it holds steady while pending.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) begin
                outRe_q[i] <= '0;
                outIm_q[i] <= '0;
            end
        end else if (copyNew || copyOld) begin
            for (int i = 0; i < 8; i++) begin
                outRe_q[i] <= srcRe[i];
                outIm_q[i] <= srcIm[i];
            end
        end
    end

    assign frm_err = frmErr_q;

    assign x0_real = outRe_q[0];
    assign x1_real = outRe_q[1];
    assign x2_real = outRe_q[2];
    assign x3_real = outRe_q[3];
    assign x4_real = outRe_q[4];
    assign x5_real = outRe_q[5];
    assign x6_real = outRe_q[6];
    assign x7_real = outRe_q[7];
    assign x0_imag = outIm_q[0];
    assign x1_imag = outIm_q[1];
    assign x2_imag = outIm_q[2];
    assign x3_imag = outIm_q[3];
    assign x4_imag = outIm_q[4];
    assign x5_imag = outIm_q[5];
    assign x6_imag = outIm_q[6];
    assign x7_imag = outIm_q[7];

endmodule

// File: tb/tb_fft8_in_buf.sv
// tb_fft8_in_buf: directed bench for the FFT input staging buffer.
module tb_fft8_in_buf;

    localparam int DW = 24;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 s_valid;
    logic                 s_ready;
    logic                 s_sop;
    logic signed [DW-1:0] s_real;
    logic signed [DW-1:0] s_imag;
    logic                 m_ready;
    logic                 en;
    logic                 frm_err;
    logic signed [DW-1:0] xr [8];
    logic signed [DW-1:0] xi [8];

    int total = 0;
    int bad   = 0;
    int ens;

    fft8_in_buf #(.DW(DW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_sop   (s_sop),
        .s_real  (s_real),
        .s_imag  (s_imag),
        .m_ready (m_ready),
        .en      (en),
        .x0_real (xr[0]),
        .x1_real (xr[1]),
        .x2_real (xr[2]),
        .x3_real (xr[3]),
        .x4_real (xr[4]),
        .x5_real (xr[5]),
        .x6_real (xr[6]),
        .x7_real (xr[7]),
        .x0_imag (xi[0]),
        .x1_imag (xi[1]),
        .x2_imag (xi[2]),
        .x3_imag (xi[3]),
        .x4_imag (xi[4]),
        .x5_imag (xi[5]),
        .x6_imag (xi[6]),
        .x7_imag (xi[7]),
        .frm_err (frm_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Drive one cycle of stream inputs, then settle just after the rising edge.
    task automatic applyStimulus(input logic v, input logic sop, input int re, input int im);
        s_valid = v;
        s_sop   = sop;
        s_real  = re[DW-1:0];
        s_imag  = im[DW-1:0];
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Directed sequence.
    initial begin
        rstn    = 1'b0;
        m_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("rst_s_ready", {31'd0, s_ready}, 1);
        checkOutput("rst_en", {31'd0, en}, 0);
        checkOutput("rst_frm_err", {31'd0, frm_err}, 0);
        checkOutput("rst_x0r", xr[0], 0);
        checkOutput("rst_x7i", xi[7], 0);
        rstn = 1'b1;

        $display("[TB] basic frame");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, k + 1, -(k + 1));
            checkOutput($sformatf("basic_en_%0d", k), {31'd0, en}, (k == 7) ? 1 : 0);
        end
        s_valid = 1'b0;
        checkOutput("basic_x0r", xr[0], 1);
        checkOutput("basic_x3r", xr[3], 4);
        checkOutput("basic_x3i", xi[3], -4);
        checkOutput("basic_x7r", xr[7], 8);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("basic_en_after", {31'd0, en}, 0);

        $display("[TB] 64-sample ramp");
        ens = 0;
        for (int k = 0; k < 64; k++) begin
            applyStimulus(1'b1, 1'b0, k, -k);
            checkOutput($sformatf("ramp_ready_%0d", k), {31'd0, s_ready}, 1);
            checkOutput($sformatf("ramp_en_%0d", k), {31'd0, en}, (k % 8 == 7) ? 1 : 0);
            if (en) begin
                ens++;
                checkOutput($sformatf("ramp_x0r_%0d", k), xr[0], k - 7);
                checkOutput($sformatf("ramp_x7i_%0d", k), xi[7], -k);
            end
        end
        checkOutput("ramp_en_count", ens, 8);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("ramp_en_idle", {31'd0, en}, 0);

        $display("[TB] backpressure");
        m_ready = 1'b0;
        for (int j = 0; j < 16; j++) begin
            applyStimulus(1'b1, 1'b0, j, j);
            checkOutput($sformatf("bp_ready_%0d", j), {31'd0, s_ready}, (j < 15) ? 1 : 0);
            checkOutput($sformatf("bp_en_%0d", j), {31'd0, en}, 0);
        end
        applyStimulus(1'b1, 1'b0, 16, 16);
        checkOutput("bp_stall_ready", {31'd0, s_ready}, 0);
        checkOutput("bp_stall_en", {31'd0, en}, 0);
        m_ready = 1'b1;
        #1;
        checkOutput("bp_first_en", {31'd0, en}, 1);
        checkOutput("bp_first_x0r", xr[0], 0);
        checkOutput("bp_first_x7r", xr[7], 7);
        applyStimulus(1'b1, 1'b0, 16, 16);
        checkOutput("bp_release_ready", {31'd0, s_ready}, 1);
        checkOutput("bp_second_en", {31'd0, en}, 1);
        checkOutput("bp_second_x0r", xr[0], 8);
        checkOutput("bp_second_x7i", xi[7], 15);
        for (int j = 16; j < 24; j++) begin
            applyStimulus(1'b1, 1'b0, j, j);
            checkOutput($sformatf("bp_tail_en_%0d", j), {31'd0, en}, (j == 23) ? 1 : 0);
        end
        checkOutput("bp_third_x0r", xr[0], 16);
        checkOutput("bp_third_x7r", xr[7], 23);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("bp_idle_en", {31'd0, en}, 0);

        $display("[TB] sop resync");
        applyStimulus(1'b1, 1'b1, 1, 1);
        checkOutput("sop_first_err", {31'd0, frm_err}, 0);
        applyStimulus(1'b1, 1'b0, 2, 2);
        applyStimulus(1'b1, 1'b0, 3, 3);
        applyStimulus(1'b1, 1'b1, 100, -100);
        checkOutput("sop_err_pulse", {31'd0, frm_err}, 1);
        checkOutput("sop_en_early", {31'd0, en}, 0);
        for (int k = 1; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, 100 + k, -(100 + k));
            checkOutput($sformatf("sop_err_low_%0d", k), {31'd0, frm_err}, 0);
            checkOutput($sformatf("sop_en_%0d", k), {31'd0, en}, (k == 7) ? 1 : 0);
        end
        checkOutput("sop_x0r", xr[0], 100);
        checkOutput("sop_x0i", xi[0], -100);
        checkOutput("sop_x3r", xr[3], 103);
        checkOutput("sop_x7r", xr[7], 107);
        applyStimulus(1'b0, 1'b0, 0, 0);

        $display("[TB] mid-frame reset");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 50 + k, 50 + k);
        end
        rstn = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("mrst_x0r", xr[0], 0);
        checkOutput("mrst_x7i", xi[7], 0);
        checkOutput("mrst_en", {31'd0, en}, 0);
        checkOutput("mrst_ready", {31'd0, s_ready}, 1);
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, 200 + k, -(200 + k));
            checkOutput($sformatf("mrst_en_%0d", k), {31'd0, en}, (k == 7) ? 1 : 0);
            checkOutput($sformatf("mrst_err_%0d", k), {31'd0, frm_err}, 0);
        end
        checkOutput("mrst_new_x0r", xr[0], 200);
        checkOutput("mrst_new_x4r", xr[4], 204);
        checkOutput("mrst_new_x7i", xi[7], -207);
        applyStimulus(1'b0, 1'b0, 0, 0);

        $display("[TB] extreme values");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, (k % 2 == 0) ? 8388607 : -8388608,
                          (k % 2 == 0) ? -8388608 : 8388607);
        end
        checkOutput("ext_en", {31'd0, en}, 1);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("ext_re_%0d", k), xr[k], (k % 2 == 0) ? 8388607 : -8388608);
            checkOutput($sformatf("ext_im_%0d", k), xi[k], (k % 2 == 0) ? -8388608 : 8388607);
        end
        applyStimulus(1'b0, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
